// File: rtl/fifo_axis_reader_pkg.sv
// Shared definitions for fifo_axis_reader and its output buffer: FSM state
// encoding, buffer depth and default widths.
`timescale 1ns/1ps
package fifo_axis_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam int unsigned BUF_DEPTH      = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LEN_WIDTH  = 16;

endpackage

// File: rtl/fifo_axis_reader_axis_out_buf.sv
// axis_out_buf: 2-entry in-order skid buffer for AXI4-Stream sources; the head
// entry (mem0) stays put while it is waiting to be popped.
`timescale 1ns/1ps
module axis_out_buf
    import fifo_axis_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & (occ != 2'd0);
    assign do_push = push & ((occ != 2'(BUF_DEPTH)) | do_pop);
    assign head    = mem0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ  <= '0;
            mem0 <= '0;
            mem1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) mem0 <= push_data;
                    else             mem1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a 1-cycle-latency FIFO into an AXI4-Stream master with
// tlast framing and graceful stop. Define FIFO_AXIS_READER_STATS_EN for pkt/stall counters.
`timescale 1ns/1ps
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
`ifdef FIFO_AXIS_READER_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           stall_count
`endif
);

    state_t                state;
    state_t                state_next;
    logic                  read_allowed;
    logic                  pending;
    logic                  pop;
    logic                  tlast_in;
    logic                  pkt_done;
    logic                  room;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [1:0]            occ;
    logic [2:0]            inflight;
    logic [DATA_WIDTH:0]   head;

    assign pop      = m_axis_tvalid & m_axis_tready;
    // The first beat of a packet uses pkt_len directly; len_q holds it afterwards.
    assign eff_len  = (cnt == '0) ? pkt_len : len_q;
    assign tlast_in = (eff_len != '0) && (cnt == eff_len - LEN_WIDTH'(1));

    // All words of the current packet have been read (or framing is disabled).
    assign pkt_done = (eff_len == '0) | (pending ? tlast_in : (cnt == '0));

    assign inflight   = {1'b0, occ} + {2'b00, pending};
    assign room       = inflight < (3'(BUF_DEPTH) + {2'b00, pop});
    assign fifo_rd_en = resetn & read_allowed & ~fifo_empty & room;

    axis_out_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (pending),
        .push_data ({tlast_in, fifo_dout}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tlast  = head[DATA_WIDTH];
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= 1'b0;
            cnt     <= '0;
            len_q   <= '0;
        end else begin
            pending <= fifo_rd_en & ~fifo_empty;
            if (cnt == '0) len_q <= pkt_len;
            if (pending) begin
                if ((eff_len == '0) || tlast_in) cnt <= '0;
                else                             cnt <= cnt + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (enable) state_next = RUN;
            RUN:      if (!enable) state_next = ((cnt == '0) && !pending) ? IDLE : STOPPING;
            STOPPING: begin
                if (enable)        state_next = RUN;
                else if (pkt_done) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // With enable low, RUN behaves like STOPPING so no word of a new packet is fetched.
    always_comb begin
        read_allowed = 1'b0;
        busy         = (state != IDLE) | (occ != 2'd0);
        case (state)
            RUN, STOPPING: read_allowed = enable | ~pkt_done;
            default:       read_allowed = 1'b0;
        endcase
    end

`ifdef FIFO_AXIS_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop & m_axis_tlast) pkt_count <= pkt_count + 32'd1;
            if (m_axis_tvalid & ~m_axis_tready & (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Self-checking bench for fifo_axis_reader: behavioural FIFO, expected stream
// derived from the written word list and packet-position arithmetic.
`timescale 1ns/1ps
module tb_fifo_axis_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic [LW-1:0] pkt_len;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
`ifdef FIFO_AXIS_READER_STATS_EN
    logic [31:0]   pkt_count;
    logic [31:0]   stall_count;
    int unsigned   stalls;
`endif
    logic          wr_req;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    fifo_axis_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .pkt_len       (pkt_len),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy)
`ifdef FIFO_AXIS_READER_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .stall_count   (stall_count)
`endif
    );

    // Behavioural FIFO: standard read mode, word appears on fifo_dout the cycle after rd_en.
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (!resetn) begin
            fq.delete();
        end else begin
            if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
            if (wr_req) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    typedef struct {
        int unsigned len;
        int unsigned nwords;
        int unsigned gap;
        int unsigned rdy;
        int unsigned exp_beats;
        int unsigned exp_lasts;
        int unsigned exp_lat;
        int unsigned exp_span;
    } vec_t;

    int unsigned   n_chk  = 0;
    int unsigned   n_fail = 0;
    logic [DW-1:0] words[$];
    int unsigned   beats, lasts, reads, cyc, first_cyc, last_cyc, cur_len;
    bit            stall_prev;
    logic [DW-1:0] stall_d;
    logic          stall_l;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic exp_last(input int unsigned k);
        return (cur_len != 0) && ((k % cur_len) == cur_len - 1);
    endfunction

    function automatic void model_clear();
        words.delete();
        beats      = 0;
        lasts      = 0;
        reads      = 0;
        first_cyc  = 0;
        last_cyc   = 0;
        stall_prev = 1'b0;
`ifdef FIFO_AXIS_READER_STATS_EN
        stalls     = 0;
`endif
    endfunction

    // Inputs were driven at this negedge; settle, check what the next edge will do, advance.
    task automatic step();
        logic pop;
        int   outst;
        #1;
        pop = m_axis_tvalid & m_axis_tready;
        if (resetn) begin
            chk("rd_en_while_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
            if (fifo_rd_en) begin
                outst = int'(reads) - int'(beats) - int'(pop);
                chk("rd_en_no_room", 64'(outst < 2), 64'd1);
            end
            if (stall_prev) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", 64'(m_axis_tdata), 64'(stall_d));
                chk("stall_tlast", 64'(m_axis_tlast), 64'(stall_l));
            end
            if (pop) begin
                if (int'(beats) < words.size()) begin
                    chk("beat_tdata", 64'(m_axis_tdata), 64'(words[beats]));
                    chk("beat_tlast", 64'(m_axis_tlast), 64'(exp_last(beats)));
                end else begin
                    chk("beat_extra", 64'(beats), 64'(words.size()));
                end
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
                if (m_axis_tlast) lasts++;
            end
            if (fifo_rd_en && !fifo_empty) reads++;
`ifdef FIFO_AXIS_READER_STATS_EN
            if (m_axis_tvalid && !m_axis_tready) stalls++;
`endif
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_d    = m_axis_tdata;
            stall_l    = m_axis_tlast;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        enable        = 1'b0;
        wr_req        = 1'b0;
        m_axis_tready = 1'b0;
        step();
        chk("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
        step();
        model_clear();
        resetn = 1'b1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
    endtask

    task automatic preload(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            wr_req  = 1'b1;
            wr_data = $urandom;
            words.push_back(wr_data);
            step();
        end
        wr_req = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        int unsigned written;
        int unsigned en_cyc;
        do_reset();
        pkt_len       = 16'(v.len);
        cur_len       = v.len;
        m_axis_tready = 1'b1;
        written       = 0;
        if (v.gap == 0) begin
            preload(v.nwords);
            written = v.nwords;
        end
        enable = 1'b1;
        en_cyc = cyc;
        for (int t = 0; t < 3000 && beats < v.nwords; t++) begin
            case (v.rdy)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = !((cyc % 4 == 1) || (cyc % 4 == 2));
                default: m_axis_tready = ($urandom_range(0, 1) != 0);
            endcase
            if (v.gap != 0 && written < v.nwords && (t % int'(v.gap)) == 0) begin
                wr_req  = 1'b1;
                wr_data = $urandom;
                words.push_back(wr_data);
                written++;
            end else begin
                wr_req = 1'b0;
            end
            step();
        end
        wr_req        = 1'b0;
        m_axis_tready = 1'b1;
        repeat (8) step();
        chk("row_beats", 64'(beats), 64'(v.exp_beats));
        chk("row_lasts", 64'(lasts), 64'(v.exp_lasts));
        if (v.exp_lat != 0) chk("row_first_latency", 64'(first_cyc - en_cyc), 64'(v.exp_lat));
        if (v.exp_span != 0) chk("row_span", 64'(last_cyc - first_cyc), 64'(v.exp_span));
`ifdef FIFO_AXIS_READER_STATS_EN
        chk("pkt_count", 64'(pkt_count), 64'(lasts));
        chk("stall_count", 64'(stall_count), 64'(stalls));
`endif
        enable = 1'b0;
        repeat (3) step();
        chk("row_idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        int unsigned r0;
        vecs[0] = '{4, 16, 0, 0, 16, 4, 3, 15};
        vecs[1] = '{4, 16, 0, 1, 16, 4, 0, 0};
        vecs[2] = '{3, 12, 3, 0, 12, 4, 0, 0};
        vecs[3] = '{1,  6, 0, 2,  6, 6, 0, 0};
        vecs[4] = '{0,  7, 0, 2,  7, 0, 0, 0};
        vecs[5] = '{5, 20, 1, 2, 20, 4, 0, 0};

        resetn        = 1'b0;
        enable        = 1'b0;
        pkt_len       = '0;
        m_axis_tready = 1'b0;
        wr_req        = 1'b0;
        wr_data       = '0;
        cyc           = 0;
        cur_len       = 0;
        model_clear();
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_row(vecs[i]);

        // Graceful stop after beat 2, then restart on a packet boundary.
        do_reset();
        pkt_len = 16'd8;
        cur_len = 8;
        m_axis_tready = 1'b1;
        preload(20);
        enable = 1'b1;
        for (int t = 0; t < 200 && beats < 3; t++) step();
        enable = 1'b0;
        repeat (40) step();
        chk("stop_beats", 64'(beats), 64'd8);
        chk("stop_lasts", 64'(lasts), 64'd1);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("stop_fifo_left", 64'(fq.size()), 64'd12);
        if (fq.size() != 0) chk("stop_fifo_head", 64'(fq[0]), 64'(words[8]));
        enable = 1'b1;
        for (int t = 0; t < 200 && beats < 20; t++) step();
        repeat (4) step();
        chk("restart_beats", 64'(beats), 64'd20);
        chk("restart_lasts", 64'(lasts), 64'd2);

        // pkt_len = 0: deasserting enable stops reads on the very next edge.
        do_reset();
        pkt_len = '0;
        cur_len = 0;
        m_axis_tready = 1'b1;
        preload(10);
        enable = 1'b1;
        for (int t = 0; t < 100 && beats < 3; t++) step();
        enable = 1'b0;
        r0 = reads;
        #1;
        chk("len0_stop_rd_en", 64'(fifo_rd_en), 64'd0);
        repeat (10) step();
        chk("len0_no_more_reads", 64'(reads), 64'(r0));
        chk("len0_drained", 64'(beats), 64'(r0));
        chk("len0_lasts", 64'(lasts), 64'd0);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_fifo_left", 64'(fq.size()), 64'(10 - r0));

        // Reset in the middle of a stalled packet, then a fresh packet.
        do_reset();
        pkt_len = 16'd8;
        cur_len = 8;
        m_axis_tready = 1'b1;
        preload(12);
        enable = 1'b1;
        for (int t = 0; t < 100 && beats < 6; t++) step();
        m_axis_tready = 1'b0;
        resetn        = 1'b0;
        enable        = 1'b0;
        #1;
        chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
        step();
        model_clear();
        resetn = 1'b1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_fifo_empty", 64'(fifo_empty), 64'd1);
        m_axis_tready = 1'b1;
        preload(8);
        enable = 1'b1;
        for (int t = 0; t < 200 && beats < 8; t++) step();
        repeat (4) step();
        chk("midrst_beats", 64'(beats), 64'd8);
        chk("midrst_lasts", 64'(lasts), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
